// File: rtl/ram_sp_clr.sv
// rtl/ram_sp_clr.sv - single-port synchronous RAM with hardware clear engine
module ram_sp_clr #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 8,
  parameter int                 DEPTH   = 256,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Counter is one bit wider than the address so DEPTH == 2**ADDR_W cannot wrap.
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   count;
  logic              accept;
  logic              in_range;
  logic              last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // clr in IDLE wins over a same-cycle access; nothing is accepted while clearing
  assign accept   = (state == IDLE) && !clr;
  assign in_range = {1'b0, addr} < DEPTH_C;
  assign last     = (count == LAST);

  // state register; reset always restarts the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr)  state_nxt = CLEAR;
      CLEAR:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs decoded from registered state only
  always_comb begin
    busy = (state == CLEAR);
    done = (state == CLEAR) && last;
  end

  // clear address counter, parked at zero while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state == CLEAR && !last) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  // single write port shared between the clear engine and user writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = din;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = count[ADDR_W-1:0];
      mem_wdata = CLR_VAL;
    end else begin
      mem_we    = accept && we && in_range;
    end
  end

  // array storage, not reset; the clear engine initialises it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // registered read port: write-first on collision, CLR_VAL out of range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= accept && re;
      if (accept && re) begin
        if (!in_range) begin
          dout <= CLR_VAL;
        end else if (we) begin
          dout <= din;
        end else begin
          dout <= mem[addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb/tb_ram_sp_clr.sv - self-checking bench for ram_sp_clr
module tb_ram_sp_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr, we, re;
  logic [7:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dv, busy, done;

  logic        clr2, we2, re2;
  logic [7:0]  addr2;
  logic [15:0] din2;
  logic [15:0] dout2;
  logic        dv2, busy2, done2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          u;
    bit          w;
    bit          r;
    logic [7:0]  a;
    logic [15:0] d;
    bit          ev;
    logic [15:0] ed;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  ram_sp_clr dut (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .re(re), .addr(addr), .din(din),
    .dout(dout), .dout_valid(dv), .busy(busy), .done(done)
  );

  ram_sp_clr #(.DEPTH(200)) dut2 (
    .clk(clk), .reset(reset), .clr(clr2), .we(we2), .re(re2), .addr(addr2), .din(din2),
    .dout(dout2), .dout_valid(dv2), .busy(busy2), .done(done2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // one accepted-cycle access; expected read data goes through the scoreboard
  task automatic drive(input bit u, input bit w, input bit r, input logic [7:0] a,
                       input logic [15:0] d, input bit ev, input logic [15:0] ed);
    logic        v;
    logic [15:0] q;
    if (!u) begin
      we = w; re = r; addr = a; din = d;
    end else begin
      we2 = w; re2 = r; addr2 = a; din2 = d;
    end
    if (ev) sb.push_back(ed);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; we2 = 1'b0; re2 = 1'b0;
    v = u ? dv2 : dv;
    q = u ? dout2 : dout;
    check($sformatf("dout_valid u%0d a%02h", u, a), 32'(v), 32'(ev));
    if (v) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow u%0d a%02h: got valid with no expected read", u, a);
      end else begin
        check($sformatf("dout u%0d a%02h", u, a), 32'(q), 32'(sb.pop_front()));
      end
    end else begin
      if (ev && sb.size() != 0) void'(sb.pop_front());
      check($sformatf("dout_hold u%0d a%02h", u, a), 32'(q), 32'(ed));
    end
  endtask

  // count clear cycles from the current one until done; optionally hammer inputs
  task automatic wait_done(input string nm, input int exp_n, input bit noise);
    int          n;
    bit          seen, bad_busy, bad_dv, bad_hold;
    logic [15:0] held;
    n = 1; seen = 0; bad_busy = 0; bad_dv = 0; bad_hold = 0;
    held = dout;
    while (!seen && n <= exp_n + 4) begin
      if (done) begin
        seen = 1;
      end else begin
        if (!busy) bad_busy = 1;
        if (noise) begin
          we = 1'b1; re = 1'b1; addr = 8'($urandom); din = 16'hFFFF; clr = 1'($urandom);
        end
        @(posedge clk); #1;
        n++;
        if (dv) bad_dv = 1;
        if (dout !== held) bad_hold = 1;
      end
    end
    we = 1'b0; re = 1'b0; clr = 1'b0;
    check({nm, "_done_cycle"}, 32'(n), 32'(exp_n));
    check({nm, "_busy_low_early"}, 32'(bad_busy), 32'd0);
    check({nm, "_valid_while_busy"}, 32'(bad_dv), 32'd0);
    check({nm, "_dout_moved"}, 32'(bad_hold), 32'd0);
    check({nm, "_busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
    check({nm, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clr = 0; we = 0; re = 0; addr = 0; din = 0;
    clr2 = 0; we2 = 0; re2 = 0; addr2 = 0; din2 = 0;

    // u, we, re, addr, din, expect valid, expect dout (read data or held value)
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h7F, 16'h0000, 1'b1, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000, 1'b1, 16'h0000});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h10, 16'hBEEF, 1'b0, 16'h0000});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h10, 16'h0000, 1'b1, 16'hBEEF});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 16'hBEEF});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h20, 16'h1234, 1'b1, 16'h1234});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, 1'b1, 16'h1234});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h10, 16'h0000, 1'b1, 16'hBEEF});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'hBEEF});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 8'hC8, 16'h5555, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'hC8, 16'h0000, 1'b1, 16'h0000});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 8'hC7, 16'h5555, 1'b0, 16'h0000});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'hC7, 16'h0000, 1'b1, 16'h5555});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 8'hC8, 16'h1234, 1'b1, 16'h0000});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'hC7, 16'h0000, 1'b1, 16'h5555});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'hFF, 16'h0000, 1'b1, 16'h0000});

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dv), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    wait_done("init", 256, 1'b0);
    check("d200_busy_idle", 32'(busy2), 32'd0);

    foreach (tbl[i])
      drive(tbl[i].u, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].ev, tbl[i].ed);

    for (int i = 0; i < 16; i++)
      drive(1'b0, 1'b1, 1'b0, 8'(i), 16'hAAAA, 1'b0, 16'hBEEF);
    drive(1'b0, 1'b0, 1'b1, 8'h05, 16'h0000, 1'b1, 16'hAAAA);
    drive(1'b0, 1'b0, 1'b1, 8'h0F, 16'h0000, 1'b1, 16'hAAAA);

    // clr beats a same-cycle write, then inputs are hammered during the clear
    clr = 1'b1; we = 1'b1; re = 1'b1; addr = 8'h05; din = 16'hFFFF;
    @(posedge clk); #1;
    clr = 1'b0; we = 1'b0; re = 1'b0;
    check("clr_drop_valid", 32'(dv), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    wait_done("clr", 256, 1'b1);
    for (int i = 0; i < 16; i++)
      drive(1'b0, 1'b0, 1'b1, 8'(i), 16'h0000, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 8'h80, 16'h0000, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000, 1'b1, 16'h0000);

    drive(1'b0, 1'b1, 1'b1, 8'h30, 16'h7777, 1'b1, 16'h7777);

    // reset at clear count 100 must restart the full clear
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done("rst_mid", 256, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h30, 16'h0000, 1'b1, 16'h0000);
    drive(1'b1, 1'b0, 1'b1, 8'hC7, 16'h0000, 1'b1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
